// File: rtl/zigzag_buf.sv
// Ping-pong reorder buffer. It takes 8x8 coefficient blocks in raster order and
// re-emits them in JPEG zigzag order, with a valid/ready handshake on both sides.
module zigzag_buf #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    logic [1:0]       full_reg, full_next;
    logic             wr_bank_reg, wr_bank_next;
    logic             rd_bank_reg, rd_bank_next;
    logic [5:0]       w_cnt_reg, w_cnt_next;
    logic [5:0]       r_cnt_reg, r_cnt_next;
    logic             wr_fire, rd_fire;
    logic [5:0]       zz_idx;
    logic [WIDTH-1:0] rd_word [2];

    // Zigzag position -> raster index.
    function automatic logic [5:0] zz_map(input logic [5:0] pos);
        case (pos)
            6'd0:  zz_map = 6'd0;  6'd1:  zz_map = 6'd1;  6'd2:  zz_map = 6'd8;  6'd3:  zz_map = 6'd16;
            6'd4:  zz_map = 6'd9;  6'd5:  zz_map = 6'd2;  6'd6:  zz_map = 6'd3;  6'd7:  zz_map = 6'd10;
            6'd8:  zz_map = 6'd17; 6'd9:  zz_map = 6'd24; 6'd10: zz_map = 6'd32; 6'd11: zz_map = 6'd25;
            6'd12: zz_map = 6'd18; 6'd13: zz_map = 6'd11; 6'd14: zz_map = 6'd4;  6'd15: zz_map = 6'd5;
            6'd16: zz_map = 6'd12; 6'd17: zz_map = 6'd19; 6'd18: zz_map = 6'd26; 6'd19: zz_map = 6'd33;
            6'd20: zz_map = 6'd40; 6'd21: zz_map = 6'd48; 6'd22: zz_map = 6'd41; 6'd23: zz_map = 6'd34;
            6'd24: zz_map = 6'd27; 6'd25: zz_map = 6'd20; 6'd26: zz_map = 6'd13; 6'd27: zz_map = 6'd6;
            6'd28: zz_map = 6'd7;  6'd29: zz_map = 6'd14; 6'd30: zz_map = 6'd21; 6'd31: zz_map = 6'd28;
            6'd32: zz_map = 6'd35; 6'd33: zz_map = 6'd42; 6'd34: zz_map = 6'd49; 6'd35: zz_map = 6'd56;
            6'd36: zz_map = 6'd57; 6'd37: zz_map = 6'd50; 6'd38: zz_map = 6'd43; 6'd39: zz_map = 6'd36;
            6'd40: zz_map = 6'd29; 6'd41: zz_map = 6'd22; 6'd42: zz_map = 6'd15; 6'd43: zz_map = 6'd23;
            6'd44: zz_map = 6'd30; 6'd45: zz_map = 6'd37; 6'd46: zz_map = 6'd44; 6'd47: zz_map = 6'd51;
            6'd48: zz_map = 6'd58; 6'd49: zz_map = 6'd59; 6'd50: zz_map = 6'd52; 6'd51: zz_map = 6'd45;
            6'd52: zz_map = 6'd38; 6'd53: zz_map = 6'd31; 6'd54: zz_map = 6'd39; 6'd55: zz_map = 6'd46;
            6'd56: zz_map = 6'd53; 6'd57: zz_map = 6'd60; 6'd58: zz_map = 6'd61; 6'd59: zz_map = 6'd54;
            6'd60: zz_map = 6'd47; 6'd61: zz_map = 6'd55; 6'd62: zz_map = 6'd62; 6'd63: zz_map = 6'd63;
            default: zz_map = pos;
        endcase
    endfunction

    assign in_ready  = !full_reg[wr_bank_reg];
    assign out_valid = full_reg[rd_bank_reg];
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;
    assign zz_idx    = zz_map(r_cnt_reg);
    assign out_data  = rd_word[rd_bank_reg];
    assign out_last  = out_valid && (r_cnt_reg == 6'd63);

    // Storage is deliberately unreset; the full flags alone decide what is visible.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [WIDTH-1:0] mem [64];

            always_ff @(posedge clk) begin
                if (wr_fire && (wr_bank_reg == 1'(gi)))
                    mem[w_cnt_reg] <= in_data;
            end

            assign rd_word[gi] = mem[zz_idx];
        end
    endgenerate

    // The write bank is never full while it is written, and the read bank is
    // always full while it is read, so both flag updates can land in one cycle.
    always_comb begin
        full_next    = full_reg;
        wr_bank_next = wr_bank_reg;
        rd_bank_next = rd_bank_reg;
        w_cnt_next   = w_cnt_reg;
        r_cnt_next   = r_cnt_reg;
        if (wr_fire) begin
            w_cnt_next = w_cnt_reg + 6'd1;
            if (w_cnt_reg == 6'd63) begin
                full_next[wr_bank_reg] = 1'b1;
                wr_bank_next           = !wr_bank_reg;
            end
        end
        if (rd_fire) begin
            r_cnt_next = r_cnt_reg + 6'd1;
            if (r_cnt_reg == 6'd63) begin
                full_next[rd_bank_reg] = 1'b0;
                rd_bank_next           = !rd_bank_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg    <= 2'b00;
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            w_cnt_reg   <= 6'd0;
            r_cnt_reg   <= 6'd0;
        end else begin
            full_reg    <= full_next;
            wr_bank_reg <= wr_bank_next;
            rd_bank_reg <= rd_bank_next;
            w_cnt_reg   <= w_cnt_next;
            r_cnt_reg   <= r_cnt_next;
        end
    end

endmodule

// File: tb/tb_zigzag_buf.sv
// Testbench for zigzag_buf. A queue model of complete zigzagged blocks is
// checked against the DUT on every cycle, under directed and random handshakes.
module tb_zigzag_buf;
    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_last;

    always #5 clk = ~clk;

    zigzag_buf #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last)
    );

    int n_cmp = 0;
    int n_err = 0;

    int           zz_ref [64];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] blk [64];
    int           wcount = 0;
    int           nblk;
    bit           rand_rd = 1'b0;
    bit           rd_force = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic         prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Per-cycle comparison; the model only knows which complete blocks await reading.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            wcount     = 0;
            prev_stall = 1'b0;
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_last", 32'(out_last), 32'd0);
        end else begin
            nblk = (exp_q.size() + 63) / 64;
            chk("out_valid", 32'(out_valid), 32'(nblk > 0));
            chk("in_ready", 32'(in_ready), 32'(nblk < 2));
            if (out_valid && nblk > 0) begin
                chk("out_data", 32'(out_data), 32'(exp_q[0]));
                chk("out_last", 32'(out_last), 32'(exp_q.size() % 64 == 1));
            end
            if (prev_stall) begin
                chk("stall_data", 32'(out_data), 32'(prev_data));
                chk("stall_last", 32'(out_last), 32'(prev_last));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && out_ready && exp_q.size() > 0)
                void'(exp_q.pop_front());
            if (in_valid && in_ready) begin
                blk[wcount] = in_data;
                wcount++;
                if (wcount == 64) begin
                    for (int p = 0; p < 64; p++) exp_q.push_back(blk[zz_ref[p]]);
                    wcount = 0;
                end
            end
        end
    end

    // Downstream ready: either forced or randomly gapped.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_rd ? ($urandom_range(0, 3) != 0) : rd_force;
        end
    end

    task automatic push(input logic [W-1:0] d);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: in_ready never rose, data %0d", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d outputs still pending", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p;
        // Walk the anti-diagonals: odd ones run down-left, even ones up-right.
        p = 0;
        for (int s = 0; s < 15; s++) begin
            int lo, hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 1) begin
                for (int r = lo; r <= hi; r++) begin zz_ref[p] = r * 8 + (s - r); p++; end
            end else begin
                for (int r = hi; r >= lo; r--) begin zz_ref[p] = r * 8 + (s - r); p++; end
            end
        end
        chk("zz_ref2", 32'(zz_ref[2]), 32'd8);
        chk("zz_ref3", 32'(zz_ref[3]), 32'd16);
        chk("zz_ref5", 32'(zz_ref[5]), 32'd2);
        chk("zz_ref20", 32'(zz_ref[20]), 32'd40);
        chk("zz_ref43", 32'(zz_ref[43]), 32'd23);
        chk("zz_ref61", 32'(zz_ref[61]), 32'd55);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single block, data = raster index.
        rd_force = 1'b1;
        for (int i = 0; i < 64; i++) push(W'(i));
        chk("single_first_valid", 32'(out_valid), 32'd1);
        chk("single_first_data", 32'(out_data), 32'd0);
        drain();

        // Three back-to-back blocks; block 1's last write meets block 0's last read.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 64; i++) begin
                in_valid = 1'b1;
                push(W'(64 * k + i));
                if (k == 1 && i == 63) begin
                    chk("simul_out_valid", 32'(out_valid), 32'd1);
                    chk("simul_next_data", 32'(out_data), 32'd64);
                    chk("simul_in_ready", 32'(in_ready), 32'd1);
                end
            end
        end
        drain();

        // Backpressure: two full banks stall the 129th input.
        rd_force = 1'b0;
        for (int i = 0; i < 128; i++) push(W'(i ^ 12'h5a5));
        in_valid = 1'b1;
        in_data  = W'(12'h777);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        rd_force = 1'b1;
        push(W'(12'h777));
        idle(2);
        drain();

        // Reset in the middle of a block.
        for (int i = 0; i < 30; i++) push(W'(i + 7));
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) push(W'(i * 3));
        drain();

        // Twenty blocks of random data with random gaps on both sides.
        rand_rd = 1'b1;
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                push(W'($urandom));
            end
        end
        rand_rd  = 1'b0;
        rd_force = 1'b1;
        drain();
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
